// File: rtl/bullet_pkg.sv
// rtl/bullet_pkg.sv - shared constants for the bullet slot table
package bullet_pkg;

   // Colour codes carried in the colour field
   localparam logic [2:0] COLOR_WHITE = 3'd0;
   localparam logic [2:0] COLOR_GREEN = 3'd1;
   localparam logic [2:0] COLOR_BLUE  = 3'd2;

   // Default slot field widths
   localparam int DEF_COORD_W = 8;
   localparam int DEF_SIZE_W  = 8;
   localparam int DEF_COLOR_W = 3;
   localparam int DEF_VEL_W   = 4;

   // Field offsets inside the packed read words: pos = {x,y}, size = {w,h}
   localparam int POS_Y_LSB  = 0;
   localparam int POS_X_LSB  = DEF_COORD_W;
   localparam int SIZE_H_LSB = 0;
   localparam int SIZE_W_LSB = DEF_SIZE_W;

   // Default field boundary behaviour
   localparam int DEF_Y_LIMIT = 200;
   localparam int DEF_Y_WRAP  = 1;

endpackage

// File: rtl/bullet_slot_alloc.sv
// rtl/bullet_slot_alloc.sv - lowest-free slot priority encoder
module bullet_slot_alloc
   import bullet_pkg::*;
#(
   parameter int N_SLOTS = 8,
   localparam int IDX_W = $clog2(N_SLOTS)
)(
   input  logic [N_SLOTS-1:0] active,
   output logic               found,
   output logic [IDX_W-1:0]   idx
);

   // Scan from the top down so the lowest inactive slot is the last one written
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = N_SLOTS - 1; i >= 0; i--) begin
         if (!active[i]) begin
            found = 1'b1;
            idx   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/bullet_pool.sv
// rtl/bullet_pool.sv - projectile slot table with spawn, tick, hit and dual read ports
module bullet_pool
   import bullet_pkg::*;
#(
   parameter int N_SLOTS   = 8,
   parameter int COORD_W   = DEF_COORD_W,
   parameter int SIZE_W    = DEF_SIZE_W,
   parameter int COLOR_W   = DEF_COLOR_W,
   parameter int VEL_W     = DEF_VEL_W,
   parameter int Y_LIMIT   = DEF_Y_LIMIT,
   parameter int Y_WRAP    = DEF_Y_WRAP,
   parameter int WRAP_MODE = 0,
   localparam int IDX_W = $clog2(N_SLOTS)
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tick,
   input  logic                 clear_all,
   input  logic                 spawn_valid,
   output logic                 spawn_ready,
   input  logic [COORD_W-1:0]   spawn_x,
   input  logic [COORD_W-1:0]   spawn_y,
   input  logic [SIZE_W-1:0]    spawn_w,
   input  logic [SIZE_W-1:0]    spawn_h,
   input  logic [COLOR_W-1:0]   spawn_color,
   input  logic [VEL_W-1:0]     spawn_vy,
   output logic [IDX_W-1:0]     spawn_idx,
   input  logic [IDX_W-1:0]     rd_idx_a,
   output logic [2*COORD_W-1:0] pos_a,
   output logic [2*SIZE_W-1:0]  size_a,
   output logic [COLOR_W-1:0]   color_a,
   output logic                 active_a,
   input  logic [IDX_W-1:0]     rd_idx_b,
   output logic [2*COORD_W-1:0] pos_b,
   output logic [2*SIZE_W-1:0]  size_b,
   output logic [COLOR_W-1:0]   color_b,
   output logic                 active_b,
   input  logic                 hit,
   output logic [IDX_W:0]       active_count
);

   // Boundary constants at the widened y arithmetic width
   localparam logic [COORD_W:0]   Y_LIM_C  = (COORD_W+1)'(Y_LIMIT);
   localparam logic [COORD_W-1:0] Y_WRAP_C = COORD_W'(Y_WRAP);

   logic [COORD_W-1:0] x_q     [N_SLOTS];
   logic [COORD_W-1:0] y_q     [N_SLOTS];
   logic [SIZE_W-1:0]  w_q     [N_SLOTS];
   logic [SIZE_W-1:0]  h_q     [N_SLOTS];
   logic [COLOR_W-1:0] color_q [N_SLOTS];
   logic [VEL_W-1:0]   vy_q    [N_SLOTS];
   logic [N_SLOTS-1:0] active_q;

   logic [COORD_W-1:0] y_nxt [N_SLOTS];
   logic [N_SLOTS-1:0] act_nxt;
   logic [N_SLOTS-1:0] load;
   logic [IDX_W:0]     cnt_nxt;
   logic [COORD_W:0]   y_sum;
   logic               free_found;
   logic               spawn_fire;
   logic               hit_i;

   bullet_slot_alloc #(.N_SLOTS(N_SLOTS)) u_alloc (
      .active (active_q),
      .found  (free_found),
      .idx    (spawn_idx)
   );

   assign spawn_ready = free_found && !clear_all;
   assign spawn_fire  = spawn_valid && spawn_ready;

   // Per-slot next state with priority clear_all > hit > spawn > tick
   always_comb begin
      load    = '0;
      act_nxt = active_q;
      cnt_nxt = '0;
      y_sum   = '0;
      hit_i   = 1'b0;
      for (int i = 0; i < N_SLOTS; i++) begin
         y_nxt[i] = y_q[i];
         // A hit on an idle slot is a no-op so it must not mask a spawn there
         hit_i = hit && (rd_idx_b == IDX_W'(i)) && active_q[i];
         y_sum = {1'b0, y_q[i]} + (COORD_W+1)'(vy_q[i]);
         if (clear_all) begin
            act_nxt[i] = 1'b0;
         end else if (hit_i) begin
            act_nxt[i] = 1'b0;
         end else if (spawn_fire && (spawn_idx == IDX_W'(i))) begin
            load[i]    = 1'b1;
            act_nxt[i] = 1'b1;
            y_nxt[i]   = spawn_y;
         end else if (tick && active_q[i]) begin
            if (y_sum >= Y_LIM_C) begin
               if (WRAP_MODE != 0) y_nxt[i] = Y_WRAP_C;
               else                act_nxt[i] = 1'b0;
            end else begin
               y_nxt[i] = y_sum[COORD_W-1:0];
            end
         end
         cnt_nxt = cnt_nxt + (IDX_W+1)'(act_nxt[i]);
      end
   end

   // Slot storage and the registered population count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q     <= '0;
         active_count <= '0;
         for (int i = 0; i < N_SLOTS; i++) begin
            x_q[i]     <= '0;
            y_q[i]     <= '0;
            w_q[i]     <= '0;
            h_q[i]     <= '0;
            color_q[i] <= '0;
            vy_q[i]    <= '0;
         end
      end else begin
         active_q     <= act_nxt;
         active_count <= cnt_nxt;
         for (int i = 0; i < N_SLOTS; i++) begin
            y_q[i] <= y_nxt[i];
            if (load[i]) begin
               x_q[i]     <= spawn_x;
               w_q[i]     <= spawn_w;
               h_q[i]     <= spawn_h;
               color_q[i] <= spawn_color;
               vy_q[i]    <= spawn_vy;
            end
         end
      end
   end

   // Two independent combinational read ports
   always_comb begin
      pos_a    = {x_q[rd_idx_a], y_q[rd_idx_a]};
      size_a   = {w_q[rd_idx_a], h_q[rd_idx_a]};
      color_a  = color_q[rd_idx_a];
      active_a = active_q[rd_idx_a];
      pos_b    = {x_q[rd_idx_b], y_q[rd_idx_b]};
      size_b   = {w_q[rd_idx_b], h_q[rd_idx_b]};
      color_b  = color_q[rd_idx_b];
      active_b = active_q[rd_idx_b];
   end

endmodule
